call_panel: RTL and testbench

- Request-side front end for the elevator core: debounces raw hall and car pushbuttons and latches each press as a request.
- Drives the core's floorButton / internalButton inputs.
- Clears each request only after the core has accepted it and then reported it serviced via nextFloorButton / nextInternalButton.
- Sits between board switches and the elevator core; the elevator core consumes its outputs and returns the feedback.

---
 rtl/call_panel.sv | 195 +++++++++++++++++++
 tb/tb_call_panel.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/call_panel.sv
// Hall/car button front end: debounces raw switches and latches requests
// until the elevator core accepts and services them. Optional LEDs: REQ_LED_EN.
module call_panel #(
  parameter int DEBOUNCE_CLKS = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] rawHall,
  input  logic [9:1]  rawCar,
  input  logic [13:0] nextFloorButton,
  input  logic [9:1]  nextInternalButton,
  output logic [13:0] floorButton,
  output logic [9:1]  internalButton,
  output logic        ackError
`ifdef REQ_LED_EN
  ,
  output logic [13:0] hallLed,
  output logic [7:1]  carLed
`endif
);

  localparam int N = 23;
  localparam int CW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CLKS - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ACKED,
    REARM
  } reqState_e;

  // Slot map: 0..13 hall bits, 14..20 car floors 1..7, 21..22 door buttons.
  logic [N-1:0] rawAll;
  logic [N-1:0] fbAll;
  logic [N-1:0] lvl;
  logic [N-1:0] lvlD;
  logic [N-1:0] press;
  logic [N-1:0] reqQ;
  logic [N-1:0] tmo;
  logic [CW-1:0] cnt [N];

  assign rawAll = {rawCar, 1'b0, rawHall[12:1], 1'b0};
  assign fbAll  = {nextInternalButton, nextFloorButton};
  assign press  = lvl & ~lvlD;

  logic unusedBits;
  assign unusedBits = ^{rawHall[0], rawHall[13],
                        fbAll[0], fbAll[13], fbAll[22:21],
                        press[0], press[13], press[22:21]};

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl  <= '0;
      lvlD <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      lvlD <= lvl;
      for (int i = 0; i < N; i++) begin
        if (rawAll[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          lvl[i] <= rawAll[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef REQ_LED_EN
  logic [2:0]  div;
  logic        blink;
  logic [20:0] ledAll;

  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= '0;
      blink <= 1'b0;
    end else begin
      div <= div + 3'd1;
      if (div == 3'd7) begin
        blink <= ~blink;
      end
    end
  end

  assign hallLed = ledAll[13:0];
  assign carLed  = ledAll[20:14];
`endif

  for (genvar g = 0; g < N; g++) begin : gSlot
    if (g == 0 || g == 13) begin : gMask
      assign reqQ[g] = 1'b0;
      assign tmo[g]  = 1'b0;
`ifdef REQ_LED_EN
      assign ledAll[g] = 1'b0;
`endif
    end else if (g >= 21) begin : gDoor
      logic q;
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= 1'b0;
        end else begin
          q <= lvl[g];
        end
      end
      assign reqQ[g] = q;
      assign tmo[g]  = 1'b0;
    end else begin : gReq
      reqState_e st;
      logic [TW-1:0] timer;
      logic q;
      logic expire;

      // Acceptance wins over an expiring timer in the same cycle.
      assign expire = (st == PENDING) && !fbAll[g] && (timer == TMR_MAX);

      always_ff @(posedge clk) begin
        if (reset) begin
          st    <= IDLE;
          timer <= '0;
          q     <= 1'b0;
        end else begin
          case (st)
            IDLE: begin
              if (press[g]) begin
                st    <= PENDING;
                timer <= '0;
                q     <= 1'b1;
              end
            end
            PENDING: begin
              if (fbAll[g]) begin
                st <= ACKED;
              end else if (expire) begin
                st    <= REARM;
                timer <= '0;
                q     <= 1'b0;
              end else begin
                timer <= timer + 1'b1;
              end
            end
            REARM: begin
              st    <= PENDING;
              timer <= '0;
              q     <= 1'b1;
            end
            ACKED: begin
              if (!fbAll[g]) begin
                if (press[g]) begin
                  st    <= PENDING;
                  timer <= '0;
                end else begin
                  st <= IDLE;
                  q  <= 1'b0;
                end
              end
            end
            default: begin
              st    <= IDLE;
              timer <= '0;
              q     <= 1'b0;
            end
          endcase
        end
      end

      assign reqQ[g] = q;
      assign tmo[g]  = expire;
`ifdef REQ_LED_EN
      assign ledAll[g] = (st == ACKED) ||
                         (((st == PENDING) || (st == REARM)) && blink);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ackError <= 1'b0;
    end else begin
      ackError <= |tmo;
    end
  end

  assign floorButton    = reqQ[13:0];
  assign internalButton = reqQ[22:14];

endmodule

// File: tb/tb_call_panel.sv
// Directed bench for call_panel: vector table plus hand-built
// sequences for timeout, simultaneous events and mid-request reset.
module tb_call_panel;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] rawHall;
  logic [9:1]  rawCar;
  logic [13:0] nextFloorButton;
  logic [9:1]  nextInternalButton;
  logic [13:0] floorButton;
  logic [9:1]  internalButton;
  logic        ackError;
`ifdef REQ_LED_EN
  logic [13:0] hallLed;
  logic [7:1]  carLed;
`endif

  call_panel #(
    .DEBOUNCE_CLKS(4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rawHall(rawHall),
    .rawCar(rawCar),
    .nextFloorButton(nextFloorButton),
    .nextInternalButton(nextInternalButton),
    .floorButton(floorButton),
    .internalButton(internalButton),
    .ackError(ackError)
`ifdef REQ_LED_EN
    ,
    .hallLed(hallLed),
    .carLed(carLed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] rh;
    logic [9:1]  rc;
    logic [13:0] nf;
    logic [9:1]  ni;
    logic [13:0] ef;
    logic [9:1]  ei;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  function automatic void add(input logic [13:0] rh, input logic [9:1] rc,
                              input logic [13:0] nf, input logic [9:1] ni,
                              input logic [13:0] ef, input logic [9:1] ei);
    vec_t v;
    v.rh = rh; v.rc = rc; v.nf = nf; v.ni = ni; v.ef = ef; v.ei = ei;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic [13:0] rh, input logic [9:1] rc,
                      input logic [13:0] nf, input logic [9:1] ni);
    rawHall = rh;
    rawCar = rc;
    nextFloorButton = nf;
    nextInternalButton = ni;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkAll(input string name, input logic [13:0] ef,
                        input logic [9:1] ei, input logic ea);
    chk({name, ".floor"}, 32'(floorButton), 32'(ef));
    chk({name, ".car"}, 32'(internalButton), 32'(ei));
    chk({name, ".ack"}, 32'(ackError), 32'(ea));
  endtask

  initial begin
    // floor-2 UP: press, accept, hold, service
    add(14'h0008, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    add(14'h0008, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    add(14'h0008, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    add(14'h0008, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    add(14'h0008, 9'h000, 14'h0000, 9'h000, 14'h0008, 9'h000);
    add(14'h0008, 9'h000, 14'h0008, 9'h000, 14'h0008, 9'h000);
    add(14'h0008, 9'h000, 14'h0008, 9'h000, 14'h0008, 9'h000);
    add(14'h0008, 9'h000, 14'h0008, 9'h000, 14'h0008, 9'h000);
    add(14'h0008, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    add(14'h0000, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    // car floor 5: 3-cycle glitch rejected
    for (int i = 0; i < 3; i++)
      add(14'h0000, 9'h010, 14'h0000, 9'h000, 14'h0000, 9'h000);
    for (int i = 0; i < 4; i++)
      add(14'h0000, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    // car floor 5: 4-cycle pulse latched past release
    for (int i = 0; i < 4; i++)
      add(14'h0000, 9'h010, 14'h0000, 9'h000, 14'h0000, 9'h000);
    add(14'h0000, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h010);
    add(14'h0000, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h010);
    add(14'h0000, 9'h000, 14'h0000, 9'h010, 14'h0000, 9'h010);
    add(14'h0000, 9'h000, 14'h0000, 9'h010, 14'h0000, 9'h010);
    add(14'h0000, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    add(14'h0000, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);
    // door-open: level follows debounce, feedback ignored
    for (int i = 0; i < 4; i++)
      add(14'h0000, 9'h080, 14'h0000, 9'h080, 14'h0000, 9'h000);
    for (int i = 0; i < 2; i++)
      add(14'h0000, 9'h080, 14'h0000, 9'h080, 14'h0000, 9'h080);
    for (int i = 0; i < 4; i++)
      add(14'h0000, 9'h000, 14'h0000, 9'h080, 14'h0000, 9'h080);
    add(14'h0000, 9'h000, 14'h0000, 9'h080, 14'h0000, 9'h000);
    add(14'h0000, 9'h000, 14'h0000, 9'h000, 14'h0000, 9'h000);

    reset = 1'b1;
    step(14'h3fff, 9'h1ff, 14'h3fff, 9'h1ff);
    step(14'h0000, 9'h000, 14'h0000, 9'h000);
    chkAll("reset", 14'h0000, 9'h000, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].rh, tbl[i].rc, tbl[i].nf, tbl[i].ni);
      chkAll($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ei, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      step(14'h2001, 9'h000, 14'h0000, 9'h000);
      chkAll($sformatf("mask%0d", i), 14'h0000, 9'h000, 1'b0);
    end
    step(14'h0000, 9'h000, 14'h0000, 9'h000);

    // floor-4 DOWN held unaccepted: 8 pending cycles, 1 rearm cycle
    for (int i = 0; i < 4; i++) begin
      step(14'h0040, 9'h000, 14'h0000, 9'h000);
      chkAll($sformatf("tmo_deb%0d", i), 14'h0000, 9'h000, 1'b0);
    end
    for (int e = 0; e < 17; e++) begin
      step(14'h0000, 9'h000, 14'h0000, 9'h000);
      chkAll($sformatf("tmo%0d", e),
             (e % 9 == 8) ? 14'h0000 : 14'h0040, 9'h000, (e % 9 == 8));
    end
    // acceptance on the expiring cycle beats the timeout
    step(14'h0000, 9'h000, 14'h0040, 9'h000);
    chkAll("tmo_race", 14'h0040, 9'h000, 1'b0);
    step(14'h0000, 9'h000, 14'h0040, 9'h000);
    chkAll("tmo_acked", 14'h0040, 9'h000, 1'b0);
    step(14'h0000, 9'h000, 14'h0000, 9'h000);
    chkAll("tmo_clr", 14'h0000, 9'h000, 1'b0);

    // floor-3 DOWN: new press coincides with service of the old one
    for (int i = 0; i < 4; i++) begin
      step(14'h0010, 9'h000, 14'h0000, 9'h000);
      chkAll($sformatf("sim_deb%0d", i), 14'h0000, 9'h000, 1'b0);
    end
    step(14'h0010, 9'h000, 14'h0000, 9'h000);
    chkAll("sim_pend", 14'h0010, 9'h000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(14'h0000, 9'h000, 14'h0010, 9'h000);
      chkAll($sformatf("sim_ack%0d", i), 14'h0010, 9'h000, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(14'h0010, 9'h000, 14'h0010, 9'h000);
      chkAll($sformatf("sim_re%0d", i), 14'h0010, 9'h000, 1'b0);
    end
    step(14'h0010, 9'h000, 14'h0000, 9'h000);
    chkAll("sim_both", 14'h0010, 9'h000, 1'b0);
    step(14'h0010, 9'h000, 14'h0000, 9'h000);
    chkAll("sim_kept", 14'h0010, 9'h000, 1'b0);
    step(14'h0010, 9'h000, 14'h0010, 9'h000);
    chkAll("sim_ack2", 14'h0010, 9'h000, 1'b0);
    step(14'h0010, 9'h000, 14'h0000, 9'h000);
    chkAll("sim_done", 14'h0000, 9'h000, 1'b0);
    step(14'h0000, 9'h000, 14'h0000, 9'h000);

    // floor-1 UP: reset while pending, then a fresh debounce is needed
    for (int i = 0; i < 4; i++) begin
      step(14'h0002, 9'h000, 14'h0000, 9'h000);
      chkAll($sformatf("rst_deb%0d", i), 14'h0000, 9'h000, 1'b0);
    end
    step(14'h0002, 9'h000, 14'h0000, 9'h000);
    chkAll("rst_pend", 14'h0002, 9'h000, 1'b0);
    reset = 1'b1;
    step(14'h0002, 9'h000, 14'h0000, 9'h000);
    chkAll("rst_mid", 14'h0000, 9'h000, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(14'h0002, 9'h000, 14'h0000, 9'h000);
      chkAll($sformatf("rst_re%0d", i), 14'h0000, 9'h000, 1'b0);
    end
    step(14'h0002, 9'h000, 14'h0000, 9'h000);
    chkAll("rst_fresh", 14'h0002, 9'h000, 1'b0);
    step(14'h0000, 9'h000, 14'h0002, 9'h000);
    step(14'h0000, 9'h000, 14'h0000, 9'h000);
    chkAll("rst_clr", 14'h0000, 9'h000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
